// File: rtl/bcd_digit_to_bin.sv
// bcd_digit_to_bin
// Digit-serial BCD-to-binary converter. BCD digits arrive most-significant
// first over a valid/ready handshake and are folded into acc = acc*10 + digit.
// Once the frame's last digit is taken, the binary result is held until the
// consumer takes it.
//
// Optional feature macro: BCD2BIN_ERR_EN
//   defined   -> non-BCD digits (A-F) and digits beyond NDIG raise out_err_o
//   undefined -> no error tracking, out_err_o tied low

module bcd_digit_to_bin #(
   parameter int NDIG = 4,
   parameter int W    = 14
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [3:0]   in_digit_i,
   input  logic         in_last_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_bin_o,
   output logic         out_err_o
);

   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           digit_accept;
   logic           result_accept;
   logic           room_left;
   logic [W-1:0]   digit_ext;

   // Handshake qualifiers are built from the registered state only, so none of
   // the outputs depend combinationally on the inputs.
   assign digit_accept  = in_valid_i && (state_q == ACC);
   assign result_accept = out_ready_i && (state_q == DONE);
   assign room_left     = (cnt_q < NDIG_C);
   assign digit_ext     = {{(W-4){1'b0}}, in_digit_i};

   // Next-state logic: accumulate digits while in ACC (dropping any beyond
   // NDIG), move to DONE on the last digit, and clear everything when the
   // consumer takes the result.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ACC: begin
            if (digit_accept) begin
               if (room_left) begin
                  acc_d = (acc_q << 3) + (acc_q << 1) + digit_ext;
                  cnt_d = cnt_q + CW'(1);
               end
               if (in_last_i) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (result_accept) begin
               state_d = ACC;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   // State, accumulator and digit counter; reset discards any partial or held
   // frame and returns to an empty ACC state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BCD2BIN_ERR_EN
   logic err_q, err_d;

   // The error flag is sticky for the whole frame: set by a non-BCD digit or by
   // a digit arriving after NDIG were already taken, cleared only when the
   // result is consumed.
   always_comb begin
      err_d = err_q;
      if (digit_accept) begin
         if (!room_left || (in_digit_i > 4'd9)) begin
            err_d = 1'b1;
         end
      end
      if (result_accept) begin
         err_d = 1'b0;
      end
   end

   // Error flag register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign out_err_o = err_q;
`else
   assign out_err_o = 1'b0;
`endif

   assign in_ready_o  = (state_q == ACC);
   assign out_valid_o = (state_q == DONE);
   assign out_bin_o   = acc_q;

endmodule
